// File: rtl/fir_tdm_mc.sv
// Time-multiplexed multi-channel FIR: one shared MAC, per-channel delay lines, shared writable coefficients.
// Define FIR_SAT_EN to clamp the narrowed output (and flag out_sat) instead of wrapping it.
module fir_tdm_mc #(
    parameter int D_W       = 16,
    parameter int C_W       = 16,
    parameter int N_TAPS    = 16,
    parameter int N_CH      = 2,
    parameter int OUT_SHIFT = 15,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int TAP_W    = $clog2(N_TAPS)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CH_W-1:0]         in_ch,
    input  logic signed [D_W-1:0]   fir_in,
    input  logic                    coef_we,
    input  logic [TAP_W-1:0]        coef_addr,
    input  logic signed [C_W-1:0]   coef_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CH_W-1:0]         out_ch,
    output logic signed [D_W-1:0]   fir_out,
    output logic                    out_sat
);

    localparam int P_W   = D_W + C_W;
    localparam int ACC_W = D_W + C_W + TAP_W;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                  state_q, state_d;
    logic signed [D_W-1:0]   x_q [N_CH][N_TAPS];
    logic signed [C_W-1:0]   coef_q [N_TAPS];
    logic [CH_W-1:0]         ch_q;
    logic [TAP_W-1:0]        k_q;
    logic signed [ACC_W-1:0] acc_q;

    logic                    ch_ok;
    logic                    accept;
    logic                    last_tap;
    logic signed [P_W-1:0]   prod;
    logic signed [D_W-1:0]   narrow;
    logic                    sat;

    assign ch_ok    = (int'(in_ch) < N_CH);
    assign accept   = (state_q == IDLE) && in_valid && ch_ok;
    assign last_tap = (k_q == TAP_W'(N_TAPS - 1));
    assign prod     = P_W'(x_q[ch_q][k_q]) * P_W'(coef_q[k_q]);

`ifdef FIR_SAT_EN
    localparam logic signed [D_W-1:0] MAX_D = {1'b0, {(D_W-1){1'b1}}};
    localparam logic signed [D_W-1:0] MIN_D = {1'b1, {(D_W-1){1'b0}}};

    logic signed [ACC_W-1:0] shifted;
    logic                    too_hi;
    logic                    too_lo;

    assign shifted = acc_q >>> OUT_SHIFT;
    assign too_hi  = shifted > ACC_W'(MAX_D);
    assign too_lo  = shifted < ACC_W'(MIN_D);
    assign sat     = too_hi || too_lo;
    assign narrow  = too_hi ? MAX_D : (too_lo ? MIN_D : shifted[D_W-1:0]);
`else
    assign sat    = 1'b0;
    assign narrow = D_W'(acc_q >>> OUT_SHIFT);
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign out_ch    = ch_q;
    assign fir_out   = (state_q == OUT) ? narrow : '0;
    assign out_sat   = (state_q == OUT) && sat;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = MAC;
            MAC:     if (last_tap)  state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Coefficients may only change in IDLE, so a MAC pass always sees one consistent set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < N_CH; c++) begin
                for (int t = 0; t < N_TAPS; t++) begin
                    x_q[c][t] <= '0;
                end
            end
            for (int t = 0; t < N_TAPS; t++) begin
                coef_q[t] <= '0;
            end
            ch_q  <= '0;
            k_q   <= '0;
            acc_q <= '0;
        end else begin
            if ((state_q == IDLE) && coef_we) begin
                coef_q[coef_addr] <= coef_data;
            end
            if (accept) begin
                x_q[in_ch][0] <= fir_in;
                for (int t = 1; t < N_TAPS; t++) begin
                    x_q[in_ch][t] <= x_q[in_ch][t-1];
                end
                ch_q  <= in_ch;
                k_q   <= '0;
                acc_q <= '0;
            end
            if (state_q == MAC) begin
                acc_q <= acc_q + ACC_W'(prod);
                k_q   <= k_q + TAP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fir_tdm_mc.sv
// Directed, table-driven bench for fir_tdm_mc at default parameters (16 taps, 2 channels).
// Overflow expectations follow FIR_SAT_EN when it is defined for the build.
module tb_fir_tdm_mc;

    localparam int LIMIT = 200;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [0:0]  in_ch;
    logic [15:0] fir_in;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [15:0] coef_data;
    logic        out_valid;
    logic        out_ready;
    logic [0:0]  out_ch;
    logic [15:0] fir_out;
    logic        out_sat;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [0:0]  ch;
        logic [15:0] smp;
        logic [15:0] expY;
    } vec_t;

    vec_t vecs[48];

    fir_tdm_mc dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .fir_in    (fir_in),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .fir_out   (fir_out),
        .out_sat   (out_sat)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Impulse 0x7FF against coef[n] = 0x4000+n, floor-shifted by 15.
    function automatic logic [15:0] impulseOut(input int n);
        longint p;
        p = 64'sh7FF * (64'sh4000 + longint'(n));
        return 16'(p >>> 15);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1;
        repeat (10) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic writeCoef(input logic [3:0] a, input logic [15:0] d);
        @(negedge clock);
        coef_we   = 1'b1;
        coef_addr = a;
        coef_data = d;
        @(negedge clock);
        coef_we   = 1'b0;
    endtask

    task automatic loadImpulseCoefs();
        for (int k = 0; k < 16; k++) writeCoef(4'(k), 16'h4000 + 16'(k));
    endtask

    // Presents one sample; sameWe writes coef[0] alongside it, midWe tries to write coef[0] during MAC.
    task automatic applyStimulus(input logic [0:0] ch, input logic [15:0] smp,
                                 input logic sameWe, input logic midWe, input logic [15:0] weData,
                                 output logic [15:0] y, output logic [0:0] yc,
                                 output logic ys, output int lat);
        @(negedge clock);
        in_valid  = 1'b1;
        in_ch     = ch;
        fir_in    = smp;
        coef_we   = sameWe;
        coef_addr = 4'd0;
        coef_data = weData;
        @(posedge clock);
        lat = 1;
        @(negedge clock);
        in_valid = 1'b0;
        coef_we  = midWe;
        while (!out_valid && lat < LIMIT) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            coef_we = 1'b0;
        end
        coef_we = 1'b0;
        y  = fir_out;
        yc = out_ch;
        ys = out_sat;
    endtask

    initial begin
        logic [15:0] y, y0;
        logic [0:0]  yc;
        logic        ys;
        logic [15:0] firstY;
        logic        firstS;
        int          lat;
        int          cnt;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_ch     = '0;
        fir_in    = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        out_ready = 1'b1;

        for (int i = 0; i < 16; i++) begin
            vecs[i].ch   = 1'b0;
            vecs[i].smp  = (i == 0) ? 16'h07FF : 16'h0000;
            vecs[i].expY = impulseOut(i);
        end
        for (int i = 0; i < 32; i++) begin
            vecs[16+i].ch   = 1'(i % 2);
            vecs[16+i].smp  = (i == 0) ? 16'h07FF : 16'h0000;
            vecs[16+i].expY = (i % 2 == 0) ? impulseOut(i / 2) : 16'h0000;
        end

        $display("[TB] reset and idle state");
        doReset();
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_fir_out", fir_out, 0);
        checkOutput("rst_out_ch", out_ch, 0);
        checkOutput("rst_out_sat", out_sat, 0);
        applyStimulus(1'b0, 16'h07FF, 1'b0, 1'b0, 16'h0, y, yc, ys, lat);
        checkOutput("zero_coef_y", y, 0);
        checkOutput("zero_coef_lat", lat, 17);

        $display("[TB] impulse response and channel isolation vectors");
        for (int i = 0; i < 48; i++) begin
            if (i == 0 || i == 16) begin
                doReset();
                loadImpulseCoefs();
            end
            applyStimulus(vecs[i].ch, vecs[i].smp, 1'b0, 1'b0, 16'h0, y, yc, ys, lat);
            checkOutput($sformatf("vec%0d_y", i), y, vecs[i].expY);
            checkOutput($sformatf("vec%0d_ch", i), yc, vecs[i].ch);
            checkOutput($sformatf("vec%0d_lat", i), lat, 17);
        end

        $display("[TB] coefficient write timing");
        doReset();
        applyStimulus(1'b0, 16'h0100, 1'b1, 1'b0, 16'h4000, y, yc, ys, lat);
        checkOutput("coef_same_cycle", y, 16'h0080);
        applyStimulus(1'b0, 16'h0100, 1'b0, 1'b1, 16'h7FFF, y, yc, ys, lat);
        checkOutput("coef_mid_mac_y", y, 16'h0080);
        applyStimulus(1'b0, 16'h0100, 1'b0, 1'b0, 16'h0, y, yc, ys, lat);
        checkOutput("coef_mid_mac_ignored", y, 16'h0080);

        $display("[TB] backpressure");
        doReset();
        loadImpulseCoefs();
        out_ready = 1'b0;
        applyStimulus(1'b1, 16'h07FF, 1'b0, 1'b0, 16'h0, y0, yc, ys, lat);
        checkOutput("bp_first_y", y0, 16'h03FF);
        checkOutput("bp_first_ch", yc, 1);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_ch    = 1'b0;
            fir_in   = 16'h1234;
            @(negedge clock);
            checkOutput($sformatf("bp_hold%0d_y", i), fir_out, y0);
            checkOutput($sformatf("bp_hold%0d_ch", i), out_ch, 1);
            checkOutput($sformatf("bp_hold%0d_in_ready", i), in_ready, 0);
            checkOutput($sformatf("bp_hold%0d_valid", i), out_valid, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) cnt++;
            @(negedge clock);
        end
        checkOutput("bp_one_output", cnt, 1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, y, yc, ys, lat);
        checkOutput("bp_in_valid_ignored", y, 0);

        $display("[TB] accumulator overflow");
        doReset();
        for (int k = 0; k < 16; k++) writeCoef(4'(k), 16'h7FFF);
        firstY = '0;
        firstS = 1'b0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 16'h7FFF, 1'b0, 1'b0, 16'h0, y, yc, ys, lat);
            if (i == 0) begin
                firstY = y;
                firstS = ys;
            end
        end
        checkOutput("ovf_first_y", firstY, 16'h7FFE);
        checkOutput("ovf_first_sat", firstS, 0);
`ifdef FIR_SAT_EN
        checkOutput("ovf_last_y", y, 16'h7FFF);
        checkOutput("ovf_last_sat", ys, 1);
`else
        checkOutput("ovf_last_y", y, 16'hFFE0);
        checkOutput("ovf_last_sat", ys, 0);
`endif

        $display("[TB] reset during MAC");
        doReset();
        loadImpulseCoefs();
        @(negedge clock);
        in_valid = 1'b1;
        in_ch    = 1'b0;
        fir_in   = 16'h07FF;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (4) @(negedge clock);
        checkOutput("mid_mac_busy", in_ready, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("mid_mac_rst_valid", out_valid, 0);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) cnt++;
            @(negedge clock);
        end
        checkOutput("mid_mac_no_output", cnt, 0);
        loadImpulseCoefs();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].ch, vecs[i].smp, 1'b0, 1'b0, 16'h0, y, yc, ys, lat);
            checkOutput($sformatf("post_rst%0d_y", i), y, vecs[i].expY);
        end
        checkOutput("post_rst_lat", lat, 17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
